// File: rtl/xps2_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame deframer, scan-code FIFO, xctrl register port.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHK_EN.
module xps2_rx #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FILT_LEN   = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rw_req,
    input  logic              rw_rnw,
    input  logic [1:0]        rw_addr,
    input  logic [DATA_W-1:0] data_to_wr,
    output logic [DATA_W-1:0] data_to_rd,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic              irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(FILT_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Index 0 = PS/2 clock line, index 1 = PS/2 data line.
    logic [1:0]    sync1_q, sync2_q, filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          clk_prev_q;
    logic          ev_c, bit_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {ps2_data, ps2_clk};
            sync2_q <= sync1_q;
        end
    end

    // A line's filtered value follows only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILT_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FW'(1);
                end
            end
        end
    end

    assign ev_c  = clk_prev_q & ~filt_q[0];
    assign bit_c = filt_q[1];

    state_t        state_q, state_nxt;
    logic [2:0]    bit_cnt_q, bit_cnt_nxt;
    logic [7:0]    shift_q, shift_nxt;
    logic [TW-1:0] to_q, to_nxt;
    logic          parity_ok_c, push_c, frame_err_set_c, parity_err_set_c;
`ifdef PS2_PARITY_CHK_EN
    logic          par_q, par_nxt;
    assign parity_ok_c = ^{shift_q, par_q};
`else
    assign parity_ok_c = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            to_q       <= '0;
            clk_prev_q <= 1'b1;
`ifdef PS2_PARITY_CHK_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            shift_q    <= shift_nxt;
            to_q       <= to_nxt;
            clk_prev_q <= filt_q[0];
`ifdef PS2_PARITY_CHK_EN
            par_q      <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt        = state_q;
        bit_cnt_nxt      = bit_cnt_q;
        shift_nxt        = shift_q;
        to_nxt           = (state_q == S_IDLE || ev_c) ? '0 : to_q + TW'(1);
        push_c           = 1'b0;
        frame_err_set_c  = 1'b0;
        parity_err_set_c = 1'b0;
`ifdef PS2_PARITY_CHK_EN
        par_nxt          = par_q;
`endif
        if (ev_c) begin
            case (state_q)
                S_IDLE: if (!bit_c) begin
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = '0;
                end
                S_DATA: begin
                    shift_nxt   = {bit_c, shift_q[7:1]};
                    bit_cnt_nxt = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_nxt = S_PARITY;
                end
                S_PARITY: begin
`ifdef PS2_PARITY_CHK_EN
                    par_nxt   = bit_c;
`endif
                    state_nxt = S_STOP;
                end
                S_STOP: begin
                    if (!bit_c)          frame_err_set_c  = 1'b1;
                    else if (parity_ok_c) push_c          = 1'b1;
                    else                 parity_err_set_c = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && to_q == TW'(TIMEOUT - 1)) begin
            state_nxt = S_IDLE;
        end
    end

    // Scan-code FIFO and sticky status bits.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_nxt;
    logic          ovf_q, perr_q, ferr_q;
    logic          rd_acc_c, wr_acc_c, pop_c, push_ok_c, full_c, not_empty_c;
    logic [2:0]    clr_c;
    logic          unused_wr;

    assign rd_acc_c    = sel & rw_req & rw_rnw;
    assign wr_acc_c    = sel & rw_req & ~rw_rnw;
    assign not_empty_c = (count_q != '0);
    assign full_c      = (count_q == CW'(FIFO_DEPTH));
    assign pop_c       = rd_acc_c && (rw_addr == 2'd0) && not_empty_c;
    assign push_ok_c   = push_c && (!full_c || pop_c);
    assign clr_c       = (wr_acc_c && rw_addr == 2'd1) ? data_to_wr[4:2] : 3'b000;
    assign unused_wr   = &{1'b0, data_to_wr[DATA_W-1:5], data_to_wr[1:0]};

    always_comb begin
        count_nxt = count_q;
        if (push_ok_c && !pop_c)      count_nxt = count_q + CW'(1);
        else if (pop_c && !push_ok_c) count_nxt = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            irq      <= 1'b0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)     rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_nxt;
            irq     <= (count_nxt != '0);
            ovf_q   <= (push_c && full_c && !pop_c) | (ovf_q & ~clr_c[0]);
            perr_q  <= parity_err_set_c | (perr_q & ~clr_c[1]);
            ferr_q  <= frame_err_set_c | (ferr_q & ~clr_c[2]);
        end
    end

    always_comb begin
        data_to_rd = '0;
        if (rd_acc_c) begin
            case (rw_addr)
                2'd0: if (not_empty_c) data_to_rd = DATA_W'(mem[rd_ptr_q]);
                2'd1: data_to_rd = DATA_W'({5'(count_q), 3'b000, ferr_q, perr_q,
                                            ovf_q, full_c, not_empty_c});
                default: data_to_rd = '0;
            endcase
        end
    end
endmodule

// File: doc/xps2_rx.md
# xps2_rx

PS/2 keyboard receiver peripheral on the xctrl read/write bus. Samples the external PS/2 clock/data lines, deframes 11-bit device-to-host frames, and buffers scan codes in a small FIFO. The controller reads scan codes and status with RDW and clears sticky errors with WRW. It is the input stage downstream of xctrl's `rw_*` port and feeds the calculator firmware.

## Interface
- `DATA_W`, default 32 (`xdefs.v`): bus data width.
- `FIFO_DEPTH`, default 8: scan-code FIFO entries; power of two, 2..16.
- `FILT_LEN`, default 8: cycles a PS/2 line must be stable before its filtered value changes.
- `TIMEOUT`, default 50000: idle `clk` cycles mid-frame before the frame is abandoned.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `sel` in 1: address decode hit for this peripheral.
- `rw_req` in 1: bus request from xctrl.
- `rw_rnw` in 1: 1 = read, 0 = write.
- `rw_addr` in 2: register offset.
- `data_to_wr` in `DATA_W`: write data.
- `data_to_rd` out `DATA_W`: read data, combinational.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `irq` out 1: high while the FIFO is non-empty.

## Operation
- **Input conditioning**
  - Both pins pass through 2-FF synchronizers, then a per-line stability filter of `FILT_LEN` cycles.
  - A frame event is a 1→0 transition of filtered `ps2_clk`; filtered `ps2_data` is sampled on that cycle.
- **Deframer FSM**, states IDLE, DATA, PARITY, STOP:
  - IDLE: on event with data=0 (start bit), go to DATA and clear bit count. Data=1 stays in IDLE.
  - DATA: shift bits LSB first; after the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: if data=1 and parity is OK, push the byte. If data=0, drop the frame and set `frame_err`. Either way, return to IDLE.
  - In any non-IDLE state, `TIMEOUT` cycles without an event returns to IDLE, discards the frame, and sets no error.
- **FIFO**, `FIFO_DEPTH` × 8 bits:
  - Push when full with no pop in the same cycle: drop the byte, set `overflow`.
  - Simultaneous push and pop when full: both succeed, no overflow.
- **Registers**, access = `sel & rw_req`:
  - Offset 0, DATA, read: `{0, fifo_head[7:0]}`. The pop occurs at the rising edge of the access cycle. A read of an empty FIFO returns 0, does not pop, and sets no error. Writes are ignored.
  - Offset 1, STATUS, read: `[0]` not_empty, `[1]` full, `[2]` overflow, `[3]` parity_err, `[4]` frame_err, `[12:8]` count, all other bits 0.
  - Offset 1, STATUS, write: bits `[4:2]` are write-1-to-clear.
  - Offsets 2 and 3: read 0, writes ignored.
  - `data_to_rd` = 0 whenever there is no read access.
- **Simultaneous events**: when an error is set and cleared by W1C in the same cycle, the set wins.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM to IDLE, FIFO empty, all sticky bits 0.
  - Synchronizers and filters to 1.
  - `irq`=0, `data_to_rd`=0.
- Reset mid-frame discards the partial frame; reception resumes at the next start bit after release.
- Pin-to-event latency: 2 synchronizer cycles + `FILT_LEN` cycles.
- Byte visibility: a stop-bit event at cycle N pushes at edge N+1; `irq`, not_empty and count update at N+1.
- Read data is valid combinationally in the request cycle, matching xctrl's same-cycle RDW capture. FIFO state updates at the end of that cycle.
- Back-to-back DATA reads on consecutive cycles pop consecutive entries.

## Configuration
- `PS2_PARITY_CHK_EN`
  - Defined: parity must be odd over data + parity bit. On mismatch the frame is dropped and `parity_err` is set.
  - Undefined: the parity bit is sampled and ignored; every frame with a valid stop bit is pushed, and `parity_err` reads 0 permanently.

## Test plan
- Frame 0x1C (parity 0, stop 1), then read DATA → returns 0x1C; STATUS then reads 0; `irq` falls after the read edge.
- Frames 0xF0, 0x1C, then STATUS read → count=2, not_empty=1. Two consecutive DATA reads → 0xF0 then 0x1C.
- Frame 0x1C with parity 1 (macro defined) → FIFO stays empty, STATUS=0x08. Write STATUS 0x08 → reads 0. With the macro undefined, the same frame pushes 0x1C.
- Nine frames with `FIFO_DEPTH`=8 and no reads → count=8, full=1, overflow=1; the first byte is read back first and the ninth is lost. Repeat with a DATA read on the 9th push cycle → no overflow.
- Start bit plus 3 data bits, then silence for `TIMEOUT`+1 cycles, then a full frame 0x5A → only 0x5A is buffered, no errors.
- Assert `rst` mid-frame after 5 data bits → outputs 0 immediately. After release, a full frame 0x29 → reads 0x29.
